// File: rtl/data_sram_like_slave_pkg.sv
// Shared SRAM-like bus encodings and the LFSR used for pseudo-random addr_ok gating.
// Reused by the bridge, the stage logic and the data RAM responder.
package data_sram_like_slave_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Right-shifting Fibonacci form: bits 0,2,3,5 realise taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/data_sram_like_slave_resp_queue.sv
// In-order response FIFO whose entries count down LATENCY-1 cycles before becoming ready.
// head_ready is the pop condition; push is only legal while count < DEPTH.
module sram_like_resp_queue #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         push_is_wr,
    input  logic [31:0]                  push_data,
    input  logic                         pop,
    output logic                         head_ready,
    output logic                         head_is_wr,
    output logic [31:0]                  head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY - 1);

    logic [DEPTH-1:0] vld;
    logic             is_wr [DEPTH];
    logic [31:0]      data  [DEPTH];
    logic [CNTW-1:0]  cnt   [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_ready = vld[head] && (cnt[head] == '0);
    assign head_is_wr = is_wr[head];
    assign head_data  = data[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= ptr_inc(head);
            end
            // The tail slot is free whenever push is allowed, so it never races the decrement above.
            if (push) begin
                vld[tail]   <= 1'b1;
                is_wr[tail] <= push_is_wr;
                data[tail]  <= push_data;
                cnt[tail]   <= CNT_INIT;
                tail        <= ptr_inc(tail);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like responder: word memory, accept gating and in-order responses LATENCY cycles
// after accept; addr_ok drops when MAX_OUTST responses are pending or the LFSR stall bit is low.
module data_sram_like_slave #(
    parameter int          MEM_AW    = 10,
    parameter int          LATENCY   = 2,
    parameter int          MAX_OUTST = 4,
    parameter bit          STALL_EN  = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    import data_sram_like_slave_pkg::*;

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] idx;
    logic [15:0]       lfsr;
    logic [CW-1:0]     count;
    logic              accept;
    logic              head_ready;
    logic              head_is_wr;
    logic [31:0]       head_data;
    logic              unused_bits;

    // Size is informational and the upper address bits alias; wstrb alone governs writes.
    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};
    assign idx         = addr[MEM_AW+1:2];

    assign addr_ok = ~reset & (count < FULL_CNT) & (~STALL_EN | lfsr[0]);
    assign accept  = req & addr_ok;

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_next(lfsr);
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    sram_like_resp_queue #(
        .DEPTH   (MAX_OUTST),
        .LATENCY (LATENCY)
    ) u_resp_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_is_wr (wr),
        .push_data  (mem[idx]),
        .pop        (head_ready),
        .head_ready (head_ready),
        .head_is_wr (head_is_wr),
        .head_data  (head_data),
        .count      (count)
    );

    assign data_ok = head_ready;
    assign rdata   = (head_ready && !head_is_wr) ? head_data : 32'h0;

endmodule
